rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single register-file write port among NUM_REQ writeback sources
//  (ALU, load unit, CSR unit). Uses a valid/ready handshake per source and drives a registered write port
//  (rf_we/rf_waddr/rf_wdata) one cycle after acceptance. Sits between the execute/memory stages and the regfile.
// PARAMETERS
//  NUM_REQ    3   number of writeback requesters (2..8)
//  DATA_W     32  write data width
//  ADDR_W     5   register address width
// PORTS
//  clk        in   1                  clock, all state updates on posedge
//  rst_n      in   1                  reset, synchronous, active-low
//  stall      in   1                  1 = issue no grants this cycle
//  flush      in   1                  1 = cancel the pending output write
//  req_valid  in   NUM_REQ            per-source write request
//  req_addr   in   NUM_REQ x ADDR_W   per-source destination register
//  req_data   in   NUM_REQ x DATA_W   per-source write data
//  req_ready  out  NUM_REQ            one-hot grant; transfer occurs when valid&ready
//  rf_we      out  1                  regfile write enable (registered)
//  rf_waddr   out  ADDR_W             regfile write address (registered)
//  rf_wdata   out  DATA_W             regfile write data (registered)
//  busy       out  1                  1 = any req_valid not granted this cycle
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0; req_ready=0 while rst_n=0.
//  - rr_ptr (clog2(NUM_REQ) bits): highest-priority index. Winner = first valid index scanning
//    rr_ptr, rr_ptr+1, ... modulo NUM_REQ (wrap-around at NUM_REQ-1 -> 0).
//  - req_ready combinational: one-hot winner when !stall && |req_valid; all zero otherwise. Exactly one grant max.
//  - On grant at edge N: rf_we=1 (0 if winner addr==0, x0 write dropped), rf_waddr/rf_wdata=winner's
//    fields, visible cycle N+1 for exactly one cycle; rr_ptr <= winner+1 (mod NUM_REQ).
//  - No grant: rf_we <= 0; rf_waddr/rf_wdata hold; rr_ptr holds.
//  - Granted x0 write still advances rr_ptr and consumes the request.
//  - stall=1: no grant, rr_ptr holds, rf_we <= 0. Sources must hold valid/addr/data stable until ready.
//  - flush=1: rf_we <= 0 at next edge regardless of grant; the grant in the same cycle is still issued
//    (source sees ready, transfer discarded) and rr_ptr advances.
//  - flush && stall: rf_we <= 0, no grant, rr_ptr holds.
//  - busy = |(req_valid & ~req_ready).
//  - Throughput: one write per cycle back-to-back; latency valid -> rf_we = 1 cycle when uncontended.
//  - Fairness: a continuously valid source is granted within NUM_REQ cycles absent stall.
//  - Reset mid-operation: pending rf_we dropped, rr_ptr -> 0, no partial state retained.
// CONFIGURATION
//  RF_WB_ARB_STATS_EN defined: adds output stat_grants [NUM_REQ x 16] per-source saturating grant counters,
//    +1 per valid&ready (including x0/flushed), saturate at 16'hFFFF, cleared by reset only.
//  Not defined: port and counters absent; remaining behaviour identical.
// STRUCTURE
//  Package rf_wb_arb_pkg: wb_req_t struct {addr[ADDR_W], data[DATA_W]}, localparam PTR_W, STAT_W=16,
//    function rr_pick(valid, ptr) returning one-hot grant.
//  Sub-module rr_arbiter_core: rr_ptr register + masked priority pick (valid, ptr, en -> grant, grant_idx).
//  Top: instantiates rr_arbiter_core, owns output register stage, flush/x0 gating, optional stats.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with all valid=1 -> ready=0, rf_we=0, after release first grant to src0.
//  2 Single src1 valid addr=5 data=32'hDEAD_BEEF -> ready[1] same cycle, next cycle rf_we=1 waddr=5 wdata=DEADBEEF.
//  3 All 3 valid for 6 cycles (no stall) -> grants 0,1,2,0,1,2; rf_we=1 every cycle from cycle 2.
//  4 src0 addr=0 data=32'h1234 -> ready[0]=1, next cycle rf_we=0, rr_ptr=1.
//  5 stall=1 for 2 cycles with src2 valid -> ready=0, rf_we=0, rr_ptr unchanged; stall=0 -> src2 granted.
//  6 flush=1 same cycle as src1 grant (addr=7) -> ready[1]=1, next cycle rf_we=0; next grant starts at src2.

Source files
------------

// File: rtl/rf_wb_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the regfile writeback arbiter.
package rf_wb_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int PTR_W       = $clog2(NUM_REQ_DEF);
    localparam int STAT_W      = 16;
    localparam int MAX_REQ     = 8;
    localparam int MAX_PTR_W   = 3;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

    // First valid index scanning from ptr upward, wrapping at n; one-hot result, zero if nothing valid.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [MAX_PTR_W-1:0] ptr,
                                                   input int unsigned n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !found && valid[idx[MAX_PTR_W-1:0]]) begin
                grant[idx[MAX_PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin pointer register plus masked priority pick; grant is combinational, pointer advances on grant.
module rr_arbiter_core
    import rf_wb_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0]   rr_ptr_r;
    logic [MAX_REQ-1:0] pick_s;

    // Winner selection and one-hot to index encoding
    always_comb begin
        pick_s = rr_pick(MAX_REQ'(valid), MAX_PTR_W'(rr_ptr_r), NUM_REQ);
        if (en) begin
            grant = pick_s[NUM_REQ-1:0];
        end else begin
            grant = '0;
        end
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_idx = grant_idx | (grant[i] ? IDX_W'(i) : IDX_W'(0));
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (|grant) begin
            rr_ptr_r <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : grant_idx + IDX_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: round-robin grant, registered write port, flush and x0 gating.
// Optional per-source grant counters when RF_WB_ARB_STATS_EN is defined.
module rf_wb_arbiter
    import rf_wb_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      busy
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grants
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [ADDR_W-1:0]  addr_arr_s [NUM_REQ];
    logic [DATA_W-1:0]  data_arr_s [NUM_REQ];
    logic [ADDR_W-1:0]  win_addr_s;
    logic [DATA_W-1:0]  win_data_s;
    logic               we_r;
    logic [ADDR_W-1:0]  waddr_r;
    logic [DATA_W-1:0]  wdata_r;

    // Grants are suppressed while reset is asserted as well as during stall
    rr_arbiter_core #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .en        (rst_n && !stall),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Unpack the flat request buses and select the winner's fields
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr_s[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr_s[i] = req_data[i*DATA_W +: DATA_W];
        end
        win_addr_s = addr_arr_s[grant_idx_s];
        win_data_s = data_arr_s[grant_idx_s];
    end

    // Output stage: fields follow any grant, write enable masked by flush and x0 destination
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else if (|grant_s) begin
            we_r    <= !flush && (win_addr_s != '0);
            waddr_r <= win_addr_s;
            wdata_r <= win_data_s;
        end else begin
            we_r    <= 1'b0;
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
        end
    end

    assign req_ready = grant_s;
    assign busy      = |(req_valid & ~grant_s);
    assign rf_we     = we_r;
    assign rf_waddr  = waddr_r;
    assign rf_wdata  = wdata_r;

`ifdef RF_WB_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_r;

    // Saturating per-source grant counters, flushed and x0 transfers included
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                stat_r[i] <= '0;
            end else if (grant_s[i] && req_valid[i] && stat_r[i] != {STAT_W{1'b1}}) begin
                stat_r[i] <= stat_r[i] + STAT_W'(1);
            end else begin
                stat_r[i] <= stat_r[i];
            end
        end
    end

    assign stat_grants = stat_r;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rf_wb_arbiter;
    import rf_wb_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          flush;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;
`ifdef RF_WB_ARB_STATS_EN
    logic [N*STAT_W-1:0] stat_grants;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            ptr = 0;
    int            win = -1;
    logic [N-1:0]  exp_ready;
    logic          exp_busy;
    logic          exp_we;
    wb_req_t       exp_out;

    rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
`ifdef RF_WB_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive control inputs and predict this cycle's grant from the round-robin rule
    task automatic apply(input logic rst, input logic st, input logic fl, input logic [N-1:0] v);
        rst_n = rst;
        stall = st;
        flush = fl;
        req_valid = v;
        #1;
        win = -1;
        if (rst && !st) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_busy = |(v & ~exp_ready);
    endtask

    // Advance one clock and update the predicted write-port contents
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            ptr = 0;
            exp_we = 1'b0;
            exp_out = '0;
        end else if (win >= 0) begin
            exp_out.addr = req_addr[win*AW +: AW];
            exp_out.data = req_data[win*DW +: DW];
            exp_we = !flush && (exp_out.addr != 0);
            ptr = (win + 1) % N;
        end else begin
            exp_we = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_src(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 1'b0, 3'b111);
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready got %b want 000", req_ready);
            end
            tick();
            checks++;
            if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_out got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
            end
        end
        apply(1'b1, 1'b0, 1'b0, 3'b111);
        checks++;
        if (req_ready !== 3'b001 || req_ready !== exp_ready) begin
            errors++;
            $display("FAIL reset_first_grant got %b want 001", req_ready);
        end
        tick();
    endtask

    task automatic test_single();
        set_src(1, 5'd5, 32'hDEAD_BEEF);
        apply(1'b1, 1'b0, 1'b0, 3'b010);
        checks++;
        if (req_ready !== 3'b010 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_ready got %b busy=%b want 010 busy=0", req_ready, busy);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_round_robin();
        apply(1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        for (int k = 0; k < N; k++) set_src(k, AW'(k + 10), DW'(32'hA000 + k));
        for (int c = 0; c < 6; c++) begin
            logic [N-1:0] want;
            want = '0;
            want[c % N] = 1'b1;
            apply(1'b1, 1'b0, 1'b0, 3'b111);
            checks++;
            if (req_ready !== want || req_ready !== exp_ready || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant c=%0d got %b busy=%b want %b busy=1", c, req_ready, busy, want);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== AW'((c % N) + 10) || rf_wdata !== exp_out.data) begin
                errors++;
                $display("FAIL rr_write c=%0d got we=%b a=%0d d=%h want 1/%0d/%h", c, rf_we, rf_waddr,
                         rf_wdata, (c % N) + 10, exp_out.data);
            end
        end
    endtask

    task automatic test_x0();
        set_src(0, 5'd0, 32'h1234);
        apply(1'b1, 1'b0, 1'b0, 3'b001);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL x0_ready got %b want 001", req_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL x0_write got we=%b a=%0d d=%h want 0/0/1234", rf_we, rf_waddr, rf_wdata);
        end
        for (int k = 0; k < N; k++) set_src(k, AW'(k + 1), DW'(k));
        apply(1'b1, 1'b0, 1'b0, 3'b111);
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL x0_ptr_adv got %b want 010", req_ready);
        end
        tick();
    endtask

    task automatic test_stall();
        set_src(2, 5'd9, 32'hCAFE_0002);
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b1, 1'b0, 3'b100);
            checks++;
            if (req_ready !== 3'b000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_ready got %b busy=%b want 000 busy=1", req_ready, busy);
            end
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_we got %b want 0", rf_we);
            end
        end
        apply(1'b1, 1'b0, 1'b0, 3'b100);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL stall_release got %b want 100", req_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hCAFE_0002) begin
            errors++;
            $display("FAIL stall_write got we=%b a=%0d d=%h want 1/9/cafe0002", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_flush();
        set_src(1, 5'd7, 32'h0000_0777);
        apply(1'b1, 1'b0, 1'b1, 3'b010);
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL flush_ready got %b want 010", req_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_we got %b want 0", rf_we);
        end
        apply(1'b1, 1'b0, 1'b0, 3'b111);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL flush_next got %b want 100", req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [N-1:0] obs;
        logic rst, st, fl;
        int wait_cnt [N];
        v = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!v[k] && $urandom_range(0, 2) != 0) begin
                    v[k] = 1'b1;
                    set_src(k, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31)), $urandom);
                end
            end
            rst = ($urandom_range(0, 63) != 0);
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            apply(rst, st, fl, v);
            obs = req_ready;
            checks++;
            if (req_ready !== exp_ready || busy !== exp_busy) begin
                errors++;
                $display("FAIL rand_grant c=%0d got %b busy=%b want %b busy=%b", c, req_ready, busy,
                         exp_ready, exp_busy);
            end
            for (int k = 0; k < N; k++) begin
                if (!rst) begin
                    wait_cnt[k] = 0;
                end else if (obs[k]) begin
                    wait_cnt[k] = 0;
                    v[k] = 1'b0;
                end else if (v[k] && !st) begin
                    wait_cnt[k]++;
                    checks++;
                    if (wait_cnt[k] >= N) begin
                        errors++;
                        $display("FAIL rand_fair src=%0d waited %0d want < %0d", k, wait_cnt[k], N);
                    end
                end
            end
            tick();
            checks++;
            if (rf_we !== exp_we || rf_waddr !== exp_out.addr || rf_wdata !== exp_out.data) begin
                errors++;
                $display("FAIL rand_write c=%0d got we=%b a=%0d d=%h want %b/%0d/%h", c, rf_we, rf_waddr,
                         rf_wdata, exp_we, exp_out.addr, exp_out.data);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        exp_we = 1'b0;
        exp_out = '0;
        exp_ready = '0;
        exp_busy = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_x0();
        test_stall();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
